// File: rtl/counter_pkg.sv
// Shared encodings for the run-controlled counter: mode select and FSM state.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/counter_ctrl_if.sv
// Control/status bundle of counter_ctrl; slave is the counter, master drives it.
interface counter_ctrl_if #(
  parameter int WIDTH          = 32,
  parameter int PRESCALE_WIDTH = 16
);
  logic                      start_i;
  logic                      stop_i;
  logic [1:0]                mode_i;
  logic [PRESCALE_WIDTH-1:0] prescale_i;
  logic [WIDTH-1:0]          init_i;
  logic [WIDTH-1:0]          incr_i;
  logic [WIDTH-1:0]          limit_i;
  logic [WIDTH-1:0]          counter_o;
  logic                      busy_o;
  logic                      wrap_o;
  logic                      done_o;
  logic                      ovf_o;

  modport master (
    output start_i, stop_i, mode_i, prescale_i, init_i, incr_i, limit_i,
    input  counter_o, busy_o, wrap_o, done_o, ovf_o
  );

  modport slave (
    input  start_i, stop_i, mode_i, prescale_i, init_i, incr_i, limit_i,
    output counter_o, busy_o, wrap_o, done_o, ovf_o
  );
endinterface

// File: rtl/tick_gen.sv
// Prescale divider: tick is high for one cycle every period+1 enabled cycles.
// clr restarts the count so the first tick lands period cycles after the clear.
module tick_gen #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      clr,
  input  logic                      en,
  input  logic [PRESCALE_WIDTH-1:0] period,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] count_q;

  assign tick = en && (count_q == period);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= tick ? '0 : count_q + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Run-controlled accumulator with wrap / saturate / one-shot limit handling.
// Counter, pulses and busy are all registered and change on the same edge.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input logic          clk,
  input logic          resetn,
  counter_ctrl_if.slave bus
);

  state_e                    state_q, state_d;
  mode_e                     mode_q;
  logic [PRESCALE_WIDTH-1:0] ps_q;
  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;
  logic                      wrap_q, wrap_d;
  logic                      done_q, done_d;
  logic                      busy_q;
  logic                      run;
  logic                      load;
  logic                      tick;
  logic [WIDTH:0]            sum, lim_ext, wsum;

  assign run     = (state_q == ST_RUN);
  // Stop beats a simultaneous start only while running; in IDLE/DONE stop is inert.
  assign load    = bus.start_i && !(run && bus.stop_i);
  assign lim_ext = {1'b0, bus.limit_i};
  assign sum     = {1'b0, cnt_q} + {1'b0, bus.incr_i};
  assign wsum    = sum - lim_ext - (WIDTH+1)'(1);

  tick_gen #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .clr    (load),
    .en     (run),
    .period (ps_q),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    if (run && bus.stop_i) begin
      state_d = ST_IDLE;
    end else if (load) begin
      state_d = ST_RUN;
      cnt_d   = bus.init_i;
      ovf_d   = 1'b0;
    end else if (run && tick) begin
      case (mode_q)
        MODE_SAT: begin
          if (sum > lim_ext) begin
            cnt_d = bus.limit_i;
            ovf_d = 1'b1;
          end else begin
            cnt_d = sum[WIDTH-1:0];
          end
        end
        MODE_ONESHOT: begin
          if (sum >= lim_ext) begin
            cnt_d   = bus.limit_i;
            done_d  = 1'b1;
            state_d = ST_DONE;
            if (sum > lim_ext) ovf_d = 1'b1;
          end else begin
            cnt_d = sum[WIDTH-1:0];
          end
        end
        default: begin
          // An increment larger than the limit cannot land inside the range; restart at zero.
          if (sum > lim_ext) begin
            wrap_d = 1'b1;
            ovf_d  = 1'b1;
            cnt_d  = (wsum > lim_ext) ? '0 : wsum[WIDTH-1:0];
          end else begin
            cnt_d = sum[WIDTH-1:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_WRAP;
      ps_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      busy_q  <= (state_d == ST_RUN);
      if (load) begin
        mode_q <= mode_e'(bus.mode_i);
        ps_q   <= bus.prescale_i;
      end
    end
  end

  assign bus.counter_o = cnt_q;
  assign bus.busy_o    = busy_q;
  assign bus.wrap_o    = wrap_q;
  assign bus.done_o    = done_q;
  assign bus.ovf_o     = ovf_q;

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Parametrised, run-controlled counter. It adds a programmable increment to an accumulator on each prescaler tick. Three runtime-selectable modes: modulo-wrap at a limit, saturate at a limit, and one-shot to a limit. Used as the general timing/ramp source in the datapath. It also serves as the DUT for the standard counter bench flow.

Parameters:
WIDTH, 32, counter/increment/limit/init width in bits
PRESCALE_WIDTH, 16, width of the prescale divider value

Ports:
clk  input  1  system clock, 100 MHz nominal
resetn  input  1  asynchronous active-low reset
start_i  input  1  start/restart pulse: latch mode_i and prescale_i, load init_i
stop_i  input  1  stop pulse: return to IDLE, hold counter
mode_i  input  2  0 = WRAP, 1 = SAT, 2 = ONESHOT, 3 = reserved (treated as WRAP)
prescale_i  input  PRESCALE_WIDTH  advance once every prescale_i+1 cycles
init_i  input  WIDTH  value loaded on start
incr_i  input  WIDTH  increment, unsigned, sampled live on every tick
limit_i  input  WIDTH  upper bound, unsigned, sampled live on every tick
counter_o  output  WIDTH  registered counter value
busy_o  output  1  high in RUN
wrap_o  output  1  one-cycle pulse on a WRAP-mode wrap
done_o  output  1  one-cycle pulse on ONESHOT completion
ovf_o  output  1  sticky: set on any wrap or saturation clamp, cleared by start

Behaviour:
- Single clock domain: clk.
- Reset:
  - Asynchronous assert, synchronous deassert is the system's responsibility.
  - While resetn=0: counter_o=0, busy_o=0, wrap_o=0, done_o=0, ovf_o=0, state=IDLE, prescale count=0.
  - Reset mid-RUN aborts immediately with no pulse.
- FSM states: IDLE, RUN, DONE. Register encodings are in the package.
  - IDLE/DONE to RUN on start_i.
  - RUN to IDLE on stop_i.
  - RUN to DONE on ONESHOT completion.
  - start_i in RUN restarts: reload and relatch.
  - start_i and stop_i in the same cycle: stop wins, go to IDLE, no load.
  - stop_i in IDLE/DONE: no effect.
- Start (accepted at clock edge N):
  - counter_o=init_i at N+1.
  - ovf_o cleared.
  - mode and prescale latched.
  - Prescale count cleared.
- Tick: in RUN, when prescale count == latched prescale.
  - Count resets to 0 on the tick, otherwise increments.
  - First tick edge is N+1+prescale. First incremented value is visible one cycle later.
  - prescale=0 gives a tick every cycle.
- Arithmetic: sum = counter_o + incr_i, computed in WIDTH+1 bits, unsigned.
- WRAP mode:
  - sum <= limit: next = sum.
  - sum > limit: next = sum - (limit+1), evaluated in WIDTH+1 bits; wrap_o pulses; ovf_o set.
  - If that result still exceeds limit (incr_i > limit_i): next = 0, with the same wrap_o pulse and ovf_o set.
  - limit = 2^WIDTH-1 gives natural modulo 2^WIDTH.
- SAT mode:
  - sum > limit: next = limit, ovf_o set, no pulse. Stays in RUN.
  - sum == limit: no ovf_o.
- ONESHOT mode:
  - sum >= limit: next = limit; done_o pulses one cycle in the same cycle counter_o shows limit; state=DONE; busy_o=0.
  - ovf_o set only if sum > limit.
- Hold conditions:
  - Non-tick cycles and IDLE/DONE: counter_o holds.
  - init_i > limit_i: loaded unchanged; the first tick applies the normal mode rule to sum.
- Timing:
  - wrap_o and done_o are registered and aligned with the counter_o update that caused them.
  - busy_o is registered from state.

Decomposition:
- Package counter_pkg:
  - Mode encodings: MODE_WRAP, MODE_SAT, MODE_ONESHOT.
  - FSM state encodings: ST_IDLE, ST_RUN, ST_DONE.
- Sub-module tick_gen:
  - Prescale counter with clear and enable.
  - Parametrised by PRESCALE_WIDTH.
  - Outputs a one-cycle tick.
- Next-value arithmetic and the FSM remain in counter_ctrl.

Test Plan:
1. WRAP, WIDTH=32, init=0, incr=2, limit=9, prescale=0, start -> counter_o 0,2,4,6,8,0,2; wrap_o high exactly with the 0; ovf_o=1 after the wrap; busy_o=1 throughout.
2. SAT, init=0, incr=4, limit=10, prescale=0 -> counter_o 0,4,8,10,10,10; ovf_o set when the clamp to 10 occurs; no wrap_o or done_o. Next start clears ovf_o.
3. ONESHOT, init=0, incr=3, limit=7, prescale=1 -> counter_o changes every 2 cycles: 0,3,6,7; done_o pulses with 7; busy_o falls; counter_o holds 7; ovf_o=1 (sum 9 > 7). Later start with init=1 -> RUN, counter_o=1.
4. WIDTH=8 instance, WRAP, init=100, incr=200, limit=255 -> 44 (300-256), wrap_o pulse. Then incr=200 again -> 244, no wrap.
5. Control conflicts, in RUN: start_i+stop_i same cycle -> IDLE, counter holds, no reload. stop_i alone -> busy_o=0, hold. start_i while RUN with incr_i changed from 2 to 4 mid-run -> reload init, new increments of 4.
6. Reset mid-RUN: assert resetn=0 between clock edges -> counter_o=0, busy_o=0, ovf_o=0 immediately (asynchronous); after release, IDLE until start_i.
